// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined WIDTH-bit ALU with status flags and
// valid/ready handshakes on both the operand and result sides.
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_SLT = 3'b111
    } op_e;

    // Stage 1 operand register
    logic             v1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    op_e              op1;

    // Stage 2 valid; the result/flag registers are the output ports
    logic             v2;

    // Stall control
    logic             adv2;
    logic             adv1;

    // Stage 2 combinational results
    logic [WIDTH-1:0] res_c;
    logic [WIDTH:0]   ext_c;
    logic             c_c;
    logic             v_c;

    // S2 may take a new beat when it is empty or its beat is leaving.
    // in_ready depends only on state and out_ready, never on in_valid.
    always_comb begin
        adv2     = !v2 || out_ready;
        adv1     = v1 && adv2;
        in_ready = !v1 || adv2;
    end

    assign out_valid = v2;

    // Operation datapath evaluated on the S1 operands
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        res_c = '0;
        ext_c = '0;
        c_c   = 1'b0;
        v_c   = 1'b0;
        unique case (op1)
            OP_ADD: begin
                ext_c = {1'b0, a1} + {1'b0, b1};
                res_c = ext_c[WIDTH-1:0];
                c_c   = ext_c[WIDTH];
                v_c   = (a1[WIDTH-1] == b1[WIDTH-1]) && (res_c[WIDTH-1] != a1[WIDTH-1]);
            end
            OP_SUB: begin
                // The borrow out of the extended subtraction is set exactly when a1 < b1 unsigned.
                ext_c = {1'b0, a1} - {1'b0, b1};
                res_c = ext_c[WIDTH-1:0];
                c_c   = ext_c[WIDTH];
                v_c   = (a1[WIDTH-1] != b1[WIDTH-1]) && (res_c[WIDTH-1] != a1[WIDTH-1]);
            end
            OP_AND: res_c = a1 & b1;
            OP_OR:  res_c = a1 | b1;
            OP_XOR: res_c = a1 ^ b1;
            OP_SHL: res_c = a1 << b1[SHW-1:0];
            OP_SHR: res_c = a1 >> b1[SHW-1:0];
            OP_SLT: res_c = {{(WIDTH-1){1'b0}}, ($signed(a1) < $signed(b1))};
            default: res_c = '0;
        endcase
    end

    // Stage 1: capture operands on an input handshake; clear v1 when draining with no new beat
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: only the valid bit is reset; operand registers may hold stale data while v1 is 0.
            v1 <= 1'b0;
        end else if (in_ready) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            v1 <= in_valid;
            if (in_valid) begin
                a1  <= A;
                b1  <= B;
                op1 <= op_e'(op);
            end
        end
    end

    // Stage 2: register result and flags; hold everything while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            v2     <= 1'b0;
            result <= '0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (adv1) begin
                result <= res_c;
                flag_z <= (res_c == '0);
                flag_n <= res_c[WIDTH-1];
                flag_c <= c_c;
                flag_v <= v_c;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed checks of alu_pipe at WIDTH=8 and WIDTH=16.
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       flag_z, flag_n, flag_c, flag_v;

    logic        in_valid16;
    logic        in_ready16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic [2:0]  op16;
    logic        out_valid16;
    logic        out_ready16;
    logic [15:0] result16;
    logic        z16, n16, c16, v16;

    int total = 0;
    int bad   = 0;

    alu_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
    );

    alu_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .A(a16), .B(b16), .op(op16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .result(result16),
        .flag_z(z16), .flag_n(n16), .flag_c(c16), .flag_v(v16)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One isolated operation; flags packed as {z,n,c,v}
    task automatic do_op(input string tag, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_res, input logic [3:0] exp_flags);
        @(negedge clk);
        in_valid  = 1'b1;
        op        = o;
        A         = a;
        B         = b;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_early"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_res"}, {24'd0, result}, {24'd0, exp_res});
        check({tag, "_flags"}, {28'd0, flag_z, flag_n, flag_c, flag_v}, {28'd0, exp_flags});
    endtask

    initial begin
        logic [7:0] sa [5];
        logic [7:0] sb [5];
        logic [7:0] se [5];
        logic [7:0] held;
        logic       hold_prev;
        logic       saw_drop;
        int         sent;
        int         rcv;

        rst         = 1'b1;
        in_valid    = 1'b0;
        A           = '0;
        B           = '0;
        op          = '0;
        out_ready   = 1'b1;
        in_valid16  = 1'b0;
        a16         = '0;
        b16         = '0;
        op16        = '0;
        out_ready16 = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", {24'd0, result}, 32'd0);
        check("rst_flags", {28'd0, flag_z, flag_n, flag_c, flag_v}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;

        // Directed operations: tag, op, A, B, result, {z,n,c,v}
        do_op("add_carry",  3'b000, 8'hF0, 8'h20, 8'h10, 4'b0010);
        do_op("add_ovf",    3'b000, 8'h7F, 8'h01, 8'h80, 4'b0101);
        do_op("sub_ovf",    3'b001, 8'h80, 8'h01, 8'h7F, 4'b0001);
        do_op("sub_zero",   3'b001, 8'h05, 8'h05, 8'h00, 4'b1000);
        do_op("sub_borrow", 3'b001, 8'h00, 8'h01, 8'hFF, 4'b0110);
        do_op("shl",        3'b101, 8'h81, 8'h09, 8'h02, 4'b0000);
        do_op("shr",        3'b110, 8'h81, 8'h07, 8'h01, 4'b0000);
        do_op("slt_true",   3'b111, 8'hFF, 8'h01, 8'h01, 4'b0000);
        do_op("slt_false",  3'b111, 8'h01, 8'hFF, 8'h00, 4'b1000);
        do_op("and",        3'b010, 8'hCC, 8'hAA, 8'h88, 4'b0100);
        do_op("or",         3'b011, 8'hCC, 8'hAA, 8'hEE, 4'b0100);
        do_op("xor",        3'b100, 8'hCC, 8'hAA, 8'h66, 4'b0000);

        // Back-pressured stream of five ADD beats, consumer stalled in cycles 3-6
        for (int i = 0; i < 5; i++) begin
            sa[i] = 8'(i * 8'h11 + 8'h03);
            sb[i] = 8'(8'h40 + i);
        end
        se[0] = 8'h43; se[1] = 8'h55; se[2] = 8'h67; se[3] = 8'h79; se[4] = 8'h8B;
        sent      = 0;
        rcv       = 0;
        hold_prev = 1'b0;
        held      = '0;
        saw_drop  = 1'b0;
        for (int cyc = 0; cyc < 40 && rcv < 5; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc <= 6);
            if (sent < 5) begin
                in_valid = 1'b1;
                op       = 3'b000;
                A        = sa[sent];
                B        = sb[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (hold_prev) begin
                check("hold_res", {24'd0, result}, {24'd0, held});
                check("hold_valid", {31'd0, out_valid}, 32'd1);
            end
            check("stream_in_ready", {31'd0, in_ready}, {31'd0, !((sent - rcv) == 2 && !out_ready)});
            if (!in_ready) saw_drop = 1'b1;
            hold_prev = out_valid && !out_ready;
            held      = result;
            if (out_valid && out_ready) begin
                check("stream_res", {24'd0, result}, {24'd0, se[rcv]});
                rcv++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_count", rcv, 5);
        check("stream_backpressure", {31'd0, saw_drop}, 32'd1);
        @(negedge clk);
        check("stream_no_dup", {31'd0, out_valid}, 32'd0);

        // Reset with two beats in flight
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op        = 3'b000;
        A         = 8'h11;
        B         = 8'h22;
        @(negedge clk);
        A = 8'h31;
        B = 8'h02;
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        check("pre_rst_res", {24'd0, result}, 32'h33);
        check("pre_rst_full", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_result", {24'd0, result}, 32'd0);
        check("midrst_flags", {28'd0, flag_z, flag_n, flag_c, flag_v}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_rst_quiet", {31'd0, out_valid}, 32'd0);
        end

        // WIDTH=16 wraparound
        @(negedge clk);
        in_valid16 = 1'b1;
        op16       = 3'b000;
        a16        = 16'hFFFF;
        b16        = 16'h0001;
        @(negedge clk);
        in_valid16 = 1'b0;
        @(negedge clk);
        check("w16_valid", {31'd0, out_valid16}, 32'd1);
        check("w16_res", {16'd0, result16}, 32'd0);
        check("w16_flags", {28'd0, z16, n16, c16, v16}, {28'd0, 4'b1010});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
